pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter: WIDTH, 64, data path width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  upstream presents in_data.
REQ-005 SHALL have port: in_ready  output  1  block can accept a word this cycle.
REQ-006 SHALL have port: in_data  input  WIDTH  upstream data word.
REQ-007 SHALL have port: out_valid  output  1  out_data holds a valid word.
REQ-008 SHALL have port: out_ready  input  1  downstream consumes out_data this cycle.
REQ-009 SHALL have port: out_data  output  WIDTH  head word presented to downstream.
REQ-010 SHALL have port: flush  input  1  synchronous discard of all held words.
REQ-011 SHALL have port: count  output  2  occupancy, 0..2.

Function
REQ-012 SHALL hold two WIDTH-bit entries: main (drives out_data) and skid (overflow).
REQ-013 SHALL define states EMPTY (count 0), ONE (main valid), FULL (main and skid valid); count SHALL equal 0/1/2 respectively.
REQ-014 SHALL define accept = in_valid & in_ready; consume = out_valid & out_ready.
REQ-015 SHALL drive out_valid = (state != EMPTY) and in_ready = (state != FULL), both decoded from registered state only; no combinational path from out_ready or in_valid to in_ready.
REQ-016 EMPTY: accept -> ONE, main <= in_data; otherwise stay.
REQ-017 ONE: accept & consume -> ONE, main <= in_data; accept only -> FULL, skid <= in_data; consume only -> EMPTY; neither -> stay.
REQ-018 FULL: consume -> ONE, main <= skid; otherwise stay; accept cannot occur because in_ready = 0.
REQ-019 SHALL deliver words in acceptance order; no word duplicated or dropped except by flush.
REQ-020 Latency: word accepted at edge N SHALL appear on out_data with out_valid = 1 in the cycle after edge N when main was empty or consumed at N.
REQ-021 Throughput: with in_valid and out_ready held high, SHALL sustain one word per cycle indefinitely.
REQ-022 flush = 1 at an edge SHALL force state EMPTY, overriding any simultaneous accept or consume; the word offered that cycle is discarded.
REQ-023 out_data SHALL hold its value while out_valid = 1 and out_ready = 0.
REQ-024 Entry registers SHALL load only on the transitions above; otherwise hold.
REQ-025 out_data content while out_valid = 0 is don't-care; the bench SHALL not check it.

Reset
REQ-026 reset = 1 SHALL immediately, without waiting for clk, force state EMPTY, count = 0, out_valid = 0, in_ready = 1, main = 0, skid = 0.
REQ-027 Reset asserted mid-transfer SHALL discard held words; the first accept after deassertion SHALL behave as from EMPTY.
REQ-028 With reset released, the first rising edge SHALL apply normal REQ-016..REQ-022 rules.

Verification
REQ-029 Reset then idle: reset pulse, no stimulus -> count = 0, out_valid = 0, in_ready = 1 asynchronously, before any clk edge.
REQ-030 Streaming: out_ready = 1, in_valid = 1 with words 1,2,3,...,10 on consecutive cycles -> out_data 1..10 on consecutive cycles, each one cycle after acceptance; count stays 1.
REQ-031 Backpressure: out_ready = 0, offer 0xA, 0xB, 0xC -> 0xA, 0xB accepted, count = 2, in_ready = 0, 0xC held upstream; raise out_ready -> out_data sequence 0xA, 0xB, 0xC, no loss.
REQ-032 Simultaneous accept/consume in ONE: main = 0x5, in_data = 0x6, both handshakes -> next cycle out_data = 0x6, count = 1.
REQ-033 Flush priority: FULL with 0x11, 0x22, flush = 1 together with out_ready = 1 -> next cycle count = 0, out_valid = 0, in_ready = 1; subsequent word 0x33 emerges alone.
REQ-034 Async reset mid-operation: FULL, assert reset between clock edges -> outputs reach REQ-026 values before next edge; after release, 0x44 accepted and output with 1-cycle latency.

Source files
------------

// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: upstream valid/ready/data, downstream valid/ready/data,
// plus flush and occupancy. The slave modport is the buffer's own view.
interface pipe_skid_reg_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
    logic [1:0]       count;

    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer: main drives out_data, skid catches the word accepted while
// downstream stalls. Ready/valid are decoded from registered state only.
//
// state | meaning
// EMPTY | nothing held, count 0
// ONE   | main valid, count 1
// FULL  | main and skid valid, count 2, in_ready low
module pipe_skid_reg #(
    parameter int WIDTH = 64
) (
    input logic             clk,
    input logic             reset,
    pipe_skid_reg_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept, consume;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        accept  = bus.in_valid & (state_q != FULL);
        consume = bus.out_ready & (state_q != EMPTY);
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_d  = bus.in_data;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    main_d  = bus.in_data;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = bus.in_data;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // flush wins over any handshake at the same edge; held entries are simply abandoned
        if (bus.flush) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        bus.out_valid = (state_q != EMPTY);
        bus.in_ready  = (state_q != FULL);
        bus.count     = state_q;
        bus.out_data  = main_q;
    end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: reset, streaming, backpressure, simultaneous
// handshake, flush priority and asynchronous reset, against hand-computed values.
module tb_pipe_skid_reg;
    localparam int WIDTH = 64;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    pipe_skid_reg_if #(.WIDTH(WIDTH)) bus ();

    pipe_skid_reg #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;

        // reset visible before the first clock edge
        #3;
        chk("rst_count", bus.count, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        #5;
        reset = 1'b0;

        // streaming 1..10, one word per cycle
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            bus.in_data = 64'(i);
            step();
            chk($sformatf("stream_data_%0d", i), bus.out_data, 64'(i));
            chk($sformatf("stream_count_%0d", i), bus.count, 1);
            chk($sformatf("stream_valid_%0d", i), bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        step();
        chk("stream_drain_count", bus.count, 0);

        // backpressure: A, B accepted, C held upstream
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'hA;
        step();
        chk("bp_count_a", bus.count, 1);
        chk("bp_data_a", bus.out_data, 64'hA);
        bus.in_data = 64'hB;
        step();
        chk("bp_count_b", bus.count, 2);
        chk("bp_in_ready_full", bus.in_ready, 0);
        bus.in_data = 64'hC;
        step();
        chk("bp_count_hold", bus.count, 2);
        chk("bp_data_hold", bus.out_data, 64'hA);
        bus.out_ready = 1'b1;
        step();
        chk("bp_data_b", bus.out_data, 64'hB);
        chk("bp_count_after_b", bus.count, 1);
        step();
        chk("bp_data_c", bus.out_data, 64'hC);
        chk("bp_count_after_c", bus.count, 1);
        bus.in_valid = 1'b0;
        step();
        chk("bp_drain_count", bus.count, 0);

        // simultaneous accept and consume in ONE
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h5;
        step();
        chk("sim_data_5", bus.out_data, 64'h5);
        bus.out_ready = 1'b1;
        bus.in_data   = 64'h6;
        step();
        chk("sim_data_6", bus.out_data, 64'h6);
        chk("sim_count", bus.count, 1);
        bus.in_valid = 1'b0;
        step();
        chk("sim_drain_count", bus.count, 0);

        // flush overrides consume in FULL
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h11;
        step();
        bus.in_data = 64'h22;
        step();
        chk("fl_count_full", bus.count, 2);
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        step();
        chk("fl_count", bus.count, 0);
        chk("fl_out_valid", bus.out_valid, 0);
        chk("fl_in_ready", bus.in_ready, 1);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h33;
        step();
        chk("fl_data_33", bus.out_data, 64'h33);
        chk("fl_count_33", bus.count, 1);
        bus.in_valid = 1'b0;
        step();
        chk("fl_alone_count", bus.count, 0);

        // flush also discards a word offered in EMPTY
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        bus.in_data  = 64'h77;
        step();
        chk("fl_empty_accept", bus.count, 0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;

        // asynchronous reset while FULL
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h55;
        step();
        bus.in_data = 64'h66;
        step();
        chk("ar_count_full", bus.count, 2);
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_count", bus.count, 0);
        chk("ar_out_valid", bus.out_valid, 0);
        chk("ar_in_ready", bus.in_ready, 1);
        chk("ar_out_data", bus.out_data, 0);
        #2;
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h44;
        step();
        chk("ar_data_44", bus.out_data, 64'h44);
        chk("ar_valid_44", bus.out_valid, 1);
        chk("ar_count_44", bus.count, 1);
        bus.in_valid = 1'b0;
        step();
        chk("ar_drain_count", bus.count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
